fb_writer: RTL and testbench
============================

# fb_writer

Frame-buffer writer: the write-side counterpart of the VGA display path, which only reads the 40x30 glyph grid from SRAM. It accepts a stream of glyph/command tokens over a valid/ready handshake, buffers them in a small FIFO, tracks a text cursor, and writes glyph bytes into the packed frame buffer (two 8-bit glyphs per 16-bit word, 20 words per row) during its dedicated arbiter slot. It also performs newline and full-screen clear.

## Interface
- DATAWIDTH, 16, memory word width; glyph = DATAWIDTH/2 bits
- FRAMEBUF, 16'd0, base word address of the frame buffer
- WSLOT, 3'd2, arbiter count value in which this block owns the memory port
- FIFO_DEPTH, 4, input token FIFO depth (power of two)
- FILL, 8'h00, glyph number written by clear

- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- acnt  input  3  arbiter clock count, increments 0..7 and wraps each cycle
- in_valid  input  1  token valid
- in_ready  output  1  FIFO not full
- in_cmd  input  2  00 glyph, 01 newline, 10 reserved (pop, no effect), 11 clear
- in_data  input  8  glyph number (in_cmd=00 only)
- mem_addr  output  DATAWIDTH  word address
- mem_wdata  output  DATAWIDTH  write data
- mem_be  output  2  byte enables; [0]=low byte, [1]=high byte
- mem_we  output  1  write strobe
- cur_col  output  6  cursor column 0..39
- cur_row  output  5  cursor row 0..29
- busy  output  1  clear in progress or FIFO non-empty

## Operation
- Handshake: token accepted on posedge when in_valid && in_ready. in_ready = (count != FIFO_DEPTH); push when full is never accepted, even with a simultaneous pop.
- Word address for column c, row r: FRAMEBUF + r*20 + c[5:1]. Byte select: c[0]=0 -> low byte (be=01, wdata={8'h00,glyph}); c[0]=1 -> high byte (be=10, wdata={glyph,8'h00}). Arithmetic in DATAWIDTH bits, wraps modulo 2^DATAWIDTH.
- States: IDLE, CLEAR.
- IDLE: at a posedge with acnt==WSLOT-1 and FIFO non-empty, pop one token:
  - 00: load mem_* for cursor position, mem_we=1; advance cursor: col+1; col 39 -> col 0, row+1; row 29/col 39 -> (0,0).
  - 01: no write; col=0, row+1 (29 -> 0).
  - 10: no write, no cursor change.
  - 11: load write of word FRAMEBUF+0 (be=11, wdata={FILL,FILL}), clear counter=1, go CLEAR.
- CLEAR: at each posedge with acnt==WSLOT-1 issue write of FRAMEBUF+counter, be=11, counter+1. The write for counter 599 is the last; at that edge go IDLE and set cursor (0,0). FIFO pushes still accepted during CLEAR; no pops.
- No write ever issued outside the acnt==WSLOT cycle.

## Timing
- All outputs registered except in_ready and busy (combinational from state/count).
- Reset (async, rst=0): state IDLE, FIFO empty, cursor (0,0), mem_addr=0, mem_wdata=0, mem_be=0, mem_we=0; hence in_ready=1, busy=0. mem_we drops immediately on reset assertion, including mid-CLEAR.
- mem_we/addr/wdata/be are loaded at the edge where acnt==WSLOT-1, valid during the entire acnt==WSLOT cycle, and mem_we/mem_be return to 0 at the following edge (addr/wdata hold).
- Throughput: one token per 8 cycles. Token pushed at edge E is poppable at the first later edge with acnt==WSLOT-1 (latency 1-8 cycles from push to write cycle).
- Clear: 600 writes over 600 consecutive slots = 4800 cycles.
- Cursor outputs update at the pop edge, same edge as mem_* load.

## Test plan
- Reset then push glyph 8'h41 (cmd 00) -> in the next acnt==2 cycle: mem_we=1, mem_addr=0, mem_be=01, mem_wdata=16'h0041; cursor (1,0).
- Push 41 glyphs 1..41 from (0,0) -> glyph 40 writes addr 19, be=10, wdata=16'h2800; glyph 41 writes addr 20, be=01; final cursor (1,1).
- Cursor at (5,29), push newline -> no mem_we pulse; cursor (0,0). Cursor (39,29), glyph -> write addr 599 be=10, cursor (0,0).
- Hold acnt frozen at 0, push 5 tokens -> in_ready=0 after 4 accepted, 5th not accepted until a pop occurs; FIFO order preserved.
- Clear with FILL=8'h20 -> exactly 600 mem_we pulses, addresses 0..599 in order, wdata=16'h2020, be=11, one per acnt==2; busy high throughout; cursor (0,0) at end; a token pushed mid-clear is written after.
- Assert rst at clear write 300 -> mem_we falls asynchronously, all outputs at reset values; after release no further writes without new tokens.

Source files
------------

// File: rtl/fb_writer.sv
// Frame-buffer writer: buffers glyph/command tokens in a small FIFO, tracks a text
// cursor and writes packed glyph bytes (or a full-screen clear) in its arbiter slot.
module fb_writer #(
  parameter int                   DATAWIDTH  = 16,
  parameter logic [DATAWIDTH-1:0] FRAMEBUF   = 16'd0,
  parameter logic [2:0]           WSLOT      = 3'd2,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [7:0]           FILL       = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           acnt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_cmd,
  input  logic [7:0]           in_data,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic [1:0]           mem_be,
  output logic                 mem_we,
  output logic [5:0]           cur_col,
  output logic [4:0]           cur_row,
  output logic                 busy,
  output logic                 state_dbg
);
  localparam int         PW        = $clog2(FIFO_DEPTH);
  localparam int         GW        = DATAWIDTH / 2;
  localparam logic [2:0] PRE_SLOT  = WSLOT - 3'd1;
  localparam logic [9:0] LAST_WORD = 10'd599;

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;

  // Handshake: a token transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on the FIFO count, never on in_valid.
  logic [9:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, empty, slot_edge;
  logic [9:0]    head;

  assign in_ready  = (count != (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = in_valid && in_ready;
  assign slot_edge = (acnt == PRE_SLOT);
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state == CLEAR) || !empty;
  assign state_dbg = (state == CLEAR);

  logic [9:0]           clr_cnt, clr_n;
  logic [5:0]           col_n;
  logic [4:0]           row_n;
  logic                 ld;
  logic [DATAWIDTH-1:0] ld_addr, ld_wdata, word_addr, fill_word;
  logic [1:0]           ld_be;

  assign word_addr = FRAMEBUF + DATAWIDTH'(cur_row) * DATAWIDTH'(20) + DATAWIDTH'(cur_col[5:1]);
  assign fill_word = (DATAWIDTH'(FILL) << GW) | DATAWIDTH'(FILL);

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    ld       = 1'b0;
    ld_addr  = mem_addr;
    ld_wdata = mem_wdata;
    ld_be    = 2'b00;
    col_n    = cur_col;
    row_n    = cur_row;
    clr_n    = clr_cnt;
    case (state)
      IDLE: begin
        if (slot_edge && !empty) begin
          pop = 1'b1;
          case (head[9:8])
            2'b00: begin
              ld      = 1'b1;
              ld_addr = word_addr;
              if (cur_col[0]) begin
                ld_be    = 2'b10;
                ld_wdata = DATAWIDTH'(head[7:0]) << GW;
              end else begin
                ld_be    = 2'b01;
                ld_wdata = DATAWIDTH'(head[7:0]);
              end
              if (cur_col == 6'd39) begin
                col_n = 6'd0;
                row_n = (cur_row == 5'd29) ? 5'd0 : cur_row + 5'd1;
              end else begin
                col_n = cur_col + 6'd1;
              end
            end
            2'b01: begin
              col_n = 6'd0;
              row_n = (cur_row == 5'd29) ? 5'd0 : cur_row + 5'd1;
            end
            2'b11: begin
              ld       = 1'b1;
              ld_addr  = FRAMEBUF;
              ld_be    = 2'b11;
              ld_wdata = fill_word;
              clr_n    = 10'd1;
              state_n  = CLEAR;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        if (slot_edge) begin
          ld       = 1'b1;
          ld_addr  = FRAMEBUF + DATAWIDTH'(clr_cnt);
          ld_be    = 2'b11;
          ld_wdata = fill_word;
          if (clr_cnt == LAST_WORD) begin
            state_n = IDLE;
            col_n   = 6'd0;
            row_n   = 5'd0;
          end else begin
            clr_n = clr_cnt + 10'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      cur_col   <= '0;
      cur_row   <= '0;
      mem_we    <= 1'b0;
      mem_be    <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_n;
      cur_col <= col_n;
      cur_row <= row_n;
      // Strobe and enables last exactly one cycle; address and data hold.
      mem_we  <= ld;
      mem_be  <= ld_be;
      if (ld) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_cmd, in_data};
  end
endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: expected memory writes are queued when tokens are
// pushed and popped by a monitor whenever the DUT strobes mem_we.
module tb_fb_writer;
  localparam logic [2:0] WSLOT = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  acnt = 3'd0;
  logic        acnt_freeze = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_cmd = 2'b00;
  logic [7:0]  in_data = 8'h00;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_we;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy, state_dbg;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [33:0] exp_q[$];  // {addr, wdata, be}

  fb_writer #(.FILL(8'h20)) dut (
    .clk(clk), .rst(rst), .acnt(acnt), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .cur_col(cur_col), .cur_row(cur_row),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / arbiter count
  always #5 clk = ~clk;
  always @(posedge clk) acnt <= acnt_freeze ? 3'd0 : acnt + 3'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write for a glyph at (col,row): word row*20+col/2, byte by col parity.
  function automatic logic [33:0] exp_glyph(input int col, input int row, input logic [7:0] g);
    logic [15:0] a;
    a = 16'(row * 20 + col / 2);
    if (col % 2 == 1) return {a, g, 8'h00, 2'b10};
    else              return {a, 8'h00, g, 2'b01};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && mem_we) begin
      logic [33:0] e;
      wr_cnt++;
      check("wr_slot", 64'(acnt), 64'(WSLOT));
      check("write_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[33:18]));
        check("wr_data", 64'(mem_wdata), 64'(e[17:2]));
        check("wr_be", 64'(mem_be), 64'(e[1:0]));
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push(input logic [1:0] cmd, input logic [7:0] data);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_cmd = cmd; in_data = data;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check("push_accept", 64'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 12000) begin @(negedge clk); #1; t++; end
    check("drain_in_time", 64'(t < 12000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, 64'(cur_col), 64'(col));
    check({tag, "_row"}, 64'(cur_row), 64'(row));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, w0, w1;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_we", 64'(mem_we), 0);
    check("rst_be", 64'(mem_be), 0);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_wdata", 64'(mem_wdata), 0);
    check("rst_ready", 64'(in_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check_cursor("rst", 0, 0);
    rst = 1'b1;

    // Single glyph
    exp_q.push_back({16'h0000, 16'h0041, 2'b01});
    push(2'b00, 8'h41);
    wait_idle();
    check_cursor("one_glyph", 1, 0);

    // Row wrap across 41 glyphs
    do_reset();
    for (int i = 1; i <= 41; i++) begin
      exp_q.push_back(exp_glyph((i - 1) % 40, (i - 1) / 40, 8'(i)));
      push(2'b00, 8'(i));
    end
    wait_idle();
    check_cursor("row_wrap", 1, 1);

    // Bottom row: newline wrap, reserved command, last-cell wrap
    do_reset();
    for (int i = 0; i < 29; i++) push(2'b01, 8'h00);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(exp_glyph(k, 29, 8'(8'h50 + k)));
      push(2'b00, 8'(8'h50 + k));
    end
    wait_idle();
    check_cursor("at_5_29", 5, 29);
    w0 = wr_cnt;
    push(2'b10, 8'hFF);
    wait_idle();
    check_cursor("reserved", 5, 29);
    push(2'b01, 8'h00);
    wait_idle();
    check_cursor("nl_wrap", 0, 0);
    check("nl_no_write", 64'(wr_cnt - w0), 0);
    for (int i = 0; i < 29; i++) push(2'b01, 8'h00);
    for (int k = 0; k < 39; k++) begin
      exp_q.push_back(exp_glyph(k, 29, 8'(8'h60 + k)));
      push(2'b00, 8'(8'h60 + k));
    end
    wait_idle();
    check_cursor("at_39_29", 39, 29);
    exp_q.push_back({16'd599, 16'h7E00, 2'b10});
    push(2'b00, 8'h7E);
    wait_idle();
    check_cursor("screen_wrap", 0, 0);

    // FIFO full with arbiter frozen
    do_reset();
    acnt_freeze = 1'b1;
    repeat (2) @(negedge clk);
    w0 = wr_cnt;
    for (int k = 0; k < 5; k++) exp_q.push_back(exp_glyph(k, 0, 8'(8'hA1 + k)));
    for (int k = 0; k < 4; k++) push(2'b00, 8'(8'hA1 + k));
    @(negedge clk);
    check("full_ready", 64'(in_ready), 0);
    check("full_busy", 64'(busy), 1);
    in_valid = 1'b1; in_cmd = 2'b00; in_data = 8'hA5;
    repeat (10) @(negedge clk);
    check("full_hold_ready", 64'(in_ready), 0);
    check("full_no_write", 64'(wr_cnt - w0), 0);
    acnt_freeze = 1'b0;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("full_reopen", 64'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();
    check_cursor("fifo_order", 5, 0);

    // Clear with a token pushed mid-clear
    do_reset();
    exp_q.push_back(exp_glyph(0, 0, 8'h11));
    push(2'b00, 8'h11);
    wait_idle();
    w0 = wr_cnt;
    for (int i = 0; i < 600; i++) exp_q.push_back({16'(i), 16'h2020, 2'b11});
    exp_q.push_back({16'h0000, 16'h0033, 2'b01});
    push(2'b11, 8'h00);
    repeat (100) @(negedge clk);
    check("clear_busy", 64'(busy), 1);
    check("clear_ready", 64'(in_ready), 1);
    push(2'b00, 8'h33);
    t = 0;
    while (busy && t < 6000) begin @(negedge clk); #1; t++; end
    check("clear_busy_span", 64'(wr_cnt - w0), 601);
    wait_idle();
    check_cursor("after_clear", 1, 0);

    // Reset in the middle of a clear
    do_reset();
    w0 = wr_cnt;
    for (int i = 0; i < 600; i++) exp_q.push_back({16'(i), 16'h2020, 2'b11});
    push(2'b11, 8'h00);
    t = 0;
    while ((wr_cnt - w0) < 301 && t < 6000) begin @(negedge clk); #1; t++; end
    check("mid_clear_we", 64'(mem_we), 1);
    check("mid_clear_addr", 64'(mem_addr), 300);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_we", 64'(mem_we), 0);
    check("async_be", 64'(mem_be), 0);
    check("async_addr", 64'(mem_addr), 0);
    check("async_wdata", 64'(mem_wdata), 0);
    check("async_busy", 64'(busy), 0);
    check("async_ready", 64'(in_ready), 1);
    check_cursor("async", 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    w1 = wr_cnt;
    repeat (100) @(negedge clk);
    #1;
    check("quiet_after_rst", 64'(wr_cnt - w1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
